// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// NIBBLE_SERIAL_ADDER_SUBTRACT_EN adds the SUB operand flag.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  logic             SUB;
`endif
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] SUM;
  logic             COUT;

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  modport master (
    output IN_VALID, A, B, CIN, SUB, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT
  );
  modport slave (
    input  IN_VALID, A, B, CIN, SUB, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT
  );
`else
  modport master (
    output IN_VALID, A, B, CIN, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT
  );
  modport slave (
    input  IN_VALID, A, B, CIN, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder reusing one 4-bit carry-lookahead cell over WIDTH/4 cycles.
// Optional NIBBLE_SERIAL_ADDER_SUBTRACT_EN: SUB=1 computes A - B.
module carry_look_ahead (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = A & B;
  assign p    = A ^ B;
  assign c[0] = CIN;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign SUM  = p ^ c[3:0];
  assign COUT = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  nibble_serial_adder_if.slave        bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  logic [1:0]       state;
  logic [CW-1:0]    cnt_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             carry_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             vld_p1;

  logic [3:0]       cell_a;
  logic [3:0]       cell_b;
  logic [3:0]       cell_sum;
  logic             cell_cout;

  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  // Subtraction is A + ~B + 1, so the inversion and forced carry happen at capture.
  assign b_in = bus.SUB ? ~bus.B : bus.B;
  assign c_in = bus.SUB ? 1'b1 : bus.CIN;
`else
  assign b_in = bus.B;
  assign c_in = bus.CIN;
`endif

  assign cell_a = a_p0[{cnt_p0, 2'b00} +: 4];
  assign cell_b = b_p0[{cnt_p0, 2'b00} +: 4];

  carry_look_ahead u_cla (
    .A    (cell_a),
    .B    (cell_b),
    .CIN  (carry_p0),
    .SUM  (cell_sum),
    .COUT (cell_cout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt_p0   <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      carry_p0 <= 1'b0;
      sum_p1   <= '0;
      cout_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        // Capture stage: operands latched, carry seeded.
        IDLE: begin
          if (bus.IN_VALID) begin
            a_p0     <= bus.A;
            b_p0     <= b_in;
            carry_p0 <= c_in;
            cnt_p0   <= '0;
            state    <= RUN;
          end
        end
        // Nibble stage: one cell evaluation per edge, LSB nibble first.
        RUN: begin
          sum_p1[{cnt_p0, 2'b00} +: 4] <= cell_sum;
          carry_p0 <= cell_cout;
          cnt_p0   <= cnt_p0 + 1'b1;
          if (cnt_p0 == LAST) begin
            cout_p1 <= cell_cout;
            vld_p1  <= 1'b1;
            state   <= DONE;
          end
        end
        // Result stage: hold until downstream takes it.
        DONE: begin
          if (bus.OUT_READY) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = (state == IDLE) & ~RST;
  assign bus.OUT_VALID = vld_p1;
  assign bus.SUM       = sum_p1;
  assign bus.COUT      = cout_p1;
endmodule
